// File: rtl/next_pc_ctrl_if.sv
// Fetch-redirect bundle between the pipeline control and the next-PC selector.
// NEXT_PC_TRAP_EN adds the trap_req request line.
interface next_pc_ctrl_if;
    logic [31:0] pc_cur;
    logic        stall_req;
    logic        br_taken;
    logic [31:0] br_target;
`ifdef NEXT_PC_TRAP_EN
    logic        trap_req;
`endif
    logic [31:0] pc_next;
    logic        pc_en;
    logic        flush;
    logic        redir_pend;
    logic        stall_timeout;

`ifdef NEXT_PC_TRAP_EN
    modport master (
        output pc_cur, stall_req, br_taken, br_target, trap_req,
        input  pc_next, pc_en, flush, redir_pend, stall_timeout
    );
    modport slave (
        input  pc_cur, stall_req, br_taken, br_target, trap_req,
        output pc_next, pc_en, flush, redir_pend, stall_timeout
    );
`else
    modport master (
        output pc_cur, stall_req, br_taken, br_target,
        input  pc_next, pc_en, flush, redir_pend, stall_timeout
    );
    modport slave (
        input  pc_cur, stall_req, br_taken, br_target,
        output pc_next, pc_en, flush, redir_pend, stall_timeout
    );
`endif
endinterface

// File: rtl/next_pc_ctrl.sv
// Next-PC selection with redirect capture across stalls and a stall watchdog.
// Optional trap redirect enabled by defining NEXT_PC_TRAP_EN.
module next_pc_ctrl #(
    parameter logic [31:0] TRAP_ADDR = 32'h0000_0100,
    parameter int          STALL_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    next_pc_ctrl_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] pend_r;
    logic        pend_trap_r;
    logic [7:0]  wdog_cnt_r;
    logic [7:0]  wdog_cnt_nx_s;
    logic        timeout_r;
    logic        trap_s;
    logic [31:0] pc_next_s;
    logic        pc_en_s;
    logic        flush_s;

`ifdef NEXT_PC_TRAP_EN
    assign trap_s = bus.trap_req;
`else
    assign trap_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: HOLD only when a redirect arrives during a stall
    always_comb begin
        state_nx_s = state_r;
        if (bus.stall_req) begin
            if (trap_s || bus.br_taken) begin
                state_nx_s = ST_HOLD;
            end else begin
                state_nx_s = state_r;
            end
        end else begin
            state_nx_s = ST_RUN;
        end
    end

    // FSM outputs: priority trap > branch > pending > sequential
    always_comb begin
        pc_next_s = bus.pc_cur;
        pc_en_s   = 1'b0;
        flush_s   = 1'b0;
        if (bus.stall_req) begin
            pc_next_s = bus.pc_cur;
            pc_en_s   = 1'b0;
            flush_s   = 1'b0;
        end else if (trap_s) begin
            pc_next_s = align_word(TRAP_ADDR);
            pc_en_s   = 1'b1;
            flush_s   = 1'b1;
        end else if (bus.br_taken) begin
            pc_next_s = align_word(bus.br_target);
            pc_en_s   = 1'b1;
            flush_s   = 1'b1;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    pc_next_s = pend_r;
                    pc_en_s   = 1'b1;
                    flush_s   = 1'b1;
                end
                ST_RUN: begin
                    pc_next_s = bus.pc_cur + 32'd4;
                    pc_en_s   = 1'b1;
                    flush_s   = 1'b0;
                end
                default: begin
                    pc_next_s = bus.pc_cur + 32'd4;
                    pc_en_s   = 1'b1;
                    flush_s   = 1'b0;
                end
            endcase
        end
    end

    // Pending redirect capture; a held trap is never replaced by a branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r      <= 32'h0000_0000;
            pend_trap_r <= 1'b0;
        end else if (bus.stall_req) begin
            if (trap_s) begin
                pend_r      <= align_word(TRAP_ADDR);
                pend_trap_r <= 1'b1;
            end else if (bus.br_taken && !((state_r == ST_HOLD) && pend_trap_r)) begin
                pend_r      <= align_word(bus.br_target);
                pend_trap_r <= 1'b0;
            end else begin
                pend_r      <= pend_r;
                pend_trap_r <= pend_trap_r;
            end
        end else begin
            pend_r      <= pend_r;
            pend_trap_r <= 1'b0;
        end
    end

    // Watchdog next count: saturating while stalled, cleared otherwise
    always_comb begin
        wdog_cnt_nx_s = 8'd0;
        if (bus.stall_req) begin
            if (wdog_cnt_r == 8'd255) begin
                wdog_cnt_nx_s = 8'd255;
            end else begin
                wdog_cnt_nx_s = wdog_cnt_r + 8'd1;
            end
        end else begin
            wdog_cnt_nx_s = 8'd0;
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_r <= 8'd0;
            timeout_r  <= 1'b0;
        end else begin
            wdog_cnt_r <= wdog_cnt_nx_s;
            timeout_r  <= timeout_r | (wdog_cnt_nx_s == 8'(STALL_MAX));
        end
    end

    assign bus.pc_next       = pc_next_s;
    assign bus.pc_en         = pc_en_s;
    assign bus.flush         = flush_s;
    assign bus.redir_pend    = (state_r == ST_HOLD);
    assign bus.stall_timeout = timeout_r;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed self-checking bench for next_pc_ctrl (STALL_MAX=4).
module tb_next_pc_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    next_pc_ctrl_if bus ();

    next_pc_ctrl #(
        .TRAP_ADDR(32'h0000_0100),
        .STALL_MAX(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic st, input logic br,
                         input logic [31:0] tgt);
        bus.pc_cur    = pc;
        bus.stall_req = st;
        bus.br_taken  = br;
        bus.br_target = tgt;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
`ifdef NEXT_PC_TRAP_EN
        bus.trap_req = 1'b0;
`endif
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("rst_redir_pend", {31'd0, bus.redir_pend}, 32'd0);
        check("rst_timeout", {31'd0, bus.stall_timeout}, 32'd0);
        rst_n = 1'b1;
        tick();

        // sequential fetch and wrap
        drive(32'h0000_0010, 1'b0, 1'b0, 32'h0);
        check("seq_pc_next", bus.pc_next, 32'h0000_0014);
        check("seq_pc_en", {31'd0, bus.pc_en}, 32'd1);
        check("seq_flush", {31'd0, bus.flush}, 32'd0);
        drive(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        check("wrap_pc_next", bus.pc_next, 32'h0000_0000);
        check("wrap_pc_en", {31'd0, bus.pc_en}, 32'd1);

        // immediate branch, target aligned
        drive(32'h0000_0010, 1'b0, 1'b1, 32'h0000_0203);
        check("br_pc_next", bus.pc_next, 32'h0000_0200);
        check("br_pc_en", {31'd0, bus.pc_en}, 32'd1);
        check("br_flush", {31'd0, bus.flush}, 32'd1);
        tick();

        // branches during a 3-cycle stall, last capture wins
        drive(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0040);
        check("st1_pc_en", {31'd0, bus.pc_en}, 32'd0);
        check("st1_flush", {31'd0, bus.flush}, 32'd0);
        check("st1_pc_next", bus.pc_next, 32'h0000_0100);
        check("st1_redir_pend", {31'd0, bus.redir_pend}, 32'd0);
        tick();
        drive(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0080);
        check("st2_redir_pend", {31'd0, bus.redir_pend}, 32'd1);
        check("st2_pc_en", {31'd0, bus.pc_en}, 32'd0);
        tick();
        drive(32'h0000_0100, 1'b1, 1'b0, 32'h0);
        check("st3_redir_pend", {31'd0, bus.redir_pend}, 32'd1);
        tick();
        drive(32'h0000_0100, 1'b0, 1'b0, 32'h0);
        check("rel_pc_next", bus.pc_next, 32'h0000_0080);
        check("rel_flush", {31'd0, bus.flush}, 32'd1);
        check("rel_pc_en", {31'd0, bus.pc_en}, 32'd1);
        tick();
        drive(32'h0000_0080, 1'b0, 1'b0, 32'h0);
        check("c5_redir_pend", {31'd0, bus.redir_pend}, 32'd0);
        check("c5_pc_next", bus.pc_next, 32'h0000_0084);
        check("c5_flush", {31'd0, bus.flush}, 32'd0);
        check("c5_no_timeout", {31'd0, bus.stall_timeout}, 32'd0);

        // branch on release beats the pending target
        drive(32'h0000_0080, 1'b1, 1'b1, 32'h0000_0040);
        tick();
        drive(32'h0000_0080, 1'b0, 1'b1, 32'h0000_0300);
        check("prec_pc_next", bus.pc_next, 32'h0000_0300);
        check("prec_flush", {31'd0, bus.flush}, 32'd1);
        tick();
        drive(32'h0000_0300, 1'b0, 1'b0, 32'h0);
        check("prec_redir_pend", {31'd0, bus.redir_pend}, 32'd0);

        // watchdog with STALL_MAX=4
        for (int i = 1; i <= 5; i++) begin
            drive(32'h0000_0300, 1'b1, 1'b0, 32'h0);
            tick();
            if (i == 3) check("wd_3", {31'd0, bus.stall_timeout}, 32'd0);
            if (i == 4) check("wd_4", {31'd0, bus.stall_timeout}, 32'd1);
            if (i == 5) check("wd_5", {31'd0, bus.stall_timeout}, 32'd1);
        end
        drive(32'h0000_0300, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("wd_sticky", {31'd0, bus.stall_timeout}, 32'd1);
        check("wd_no_hold", {31'd0, bus.redir_pend}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("wd_rst_clear", {31'd0, bus.stall_timeout}, 32'd0);
        rst_n = 1'b1;
        tick();

        // reset while holding discards the pending target
        drive(32'h0000_0300, 1'b1, 1'b1, 32'h0000_0500);
        tick();
        check("hold_redir_pend", {31'd0, bus.redir_pend}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("hold_rst_redir", {31'd0, bus.redir_pend}, 32'd0);
        drive(32'h0000_0000, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_pc_next", bus.pc_next, 32'h0000_0004);
        check("post_rst_flush", {31'd0, bus.flush}, 32'd0);
        check("post_rst_pc_en", {31'd0, bus.pc_en}, 32'd1);

`ifdef NEXT_PC_TRAP_EN
        bus.trap_req = 1'b1;
        drive(32'h0000_0010, 1'b0, 1'b1, 32'h0000_0040);
        check("trap_pc_next", bus.pc_next, 32'h0000_0100);
        check("trap_flush", {31'd0, bus.flush}, 32'd1);
        tick();
        drive(32'h0000_0010, 1'b1, 1'b1, 32'h0000_0040);
        tick();
        bus.trap_req = 1'b0;
        drive(32'h0000_0010, 1'b1, 1'b1, 32'h0000_0080);
        check("trap_hold", {31'd0, bus.redir_pend}, 32'd1);
        tick();
        drive(32'h0000_0010, 1'b0, 1'b0, 32'h0);
        check("trap_kept", bus.pc_next, 32'h0000_0100);
        tick();
        drive(32'h0000_0010, 1'b1, 1'b1, 32'h0000_0040);
        tick();
        rst_n = 1'b0;
        #1;
        check("trap_rst_redir", {31'd0, bus.redir_pend}, 32'd0);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_pc_ctrl.md
NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

Interface
REQ-001 Parameter TRAP_ADDR, default 32'h0000_0100: trap redirect address; bits [1:0] SHALL be zero.
REQ-002 Parameter STALL_MAX, default 16: stall-watchdog threshold in cycles, range 1..255.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 pc_cur  in  32  current fetch address from the PC register output.
REQ-006 stall_req  in  1  pipeline stall request (load-use or memory wait).
REQ-007 br_taken  in  1  resolved taken branch/jump this cycle.
REQ-008 br_target  in  32  branch/jump target, valid only with br_taken.
REQ-009 trap_req  in  1  trap request; present only under REQ-027.
REQ-010 pc_next  out  32  next fetch address, drives PC register input.
REQ-011 pc_en  out  1  PC register load enable.
REQ-012 flush  out  1  kill IF/ID and ID/EX contents this cycle.
REQ-013 redir_pend  out  1  a redirect is captured and waiting for stall release.
REQ-014 stall_timeout  out  1  sticky watchdog flag.

Function
REQ-015 Two states, RUN and HOLD; HOLD is entered only when a redirect is captured while stall_req=1.
REQ-016 RUN, stall_req=0, no redirect: pc_next=pc_cur+4 (modulo 2^32, 0xFFFF_FFFC wraps to 0x0000_0000), pc_en=1, flush=0.
REQ-017 RUN, stall_req=0, br_taken=1: pc_next={br_target[31:2],2'b00}, pc_en=1, flush=1, same cycle (combinational), zero added latency.
REQ-018 stall_req=1 in any state: pc_en=0, flush=0; pc_next value is don't-care but SHALL equal pc_cur.
REQ-019 RUN, stall_req=1, br_taken=1: aligned target captured into pending register at clock edge; state goes HOLD; redir_pend=1 from the next cycle.
REQ-020 HOLD, stall_req=1, br_taken=1: pending register overwritten with the new target (last capture wins).
REQ-021 HOLD, stall_req=0: pc_next=pending value, pc_en=1, flush=1; next state RUN; redir_pend=0 next cycle; a br_taken in this same cycle SHALL take precedence over the pending value.
REQ-022 Redirect priority when simultaneous: trap > branch > pending > sequential.
REQ-023 Watchdog: 8-bit counter increments each cycle stall_req=1, clears when stall_req=0, saturates at 255; stall_timeout sets when count reaches STALL_MAX and stays set until reset.
REQ-024 pc_next, pc_en, flush SHALL be combinational from state, pending register and inputs; redir_pend and stall_timeout SHALL be registered.

Reset
REQ-025 rst_n=0 asynchronously forces state RUN, pending register 0, watchdog count 0, redir_pend=0, stall_timeout=0.
REQ-026 Reset asserted in HOLD SHALL discard the pending redirect; after release, first cycle behaves per REQ-016 with pc_cur supplied by the (also reset) PC register.

Configuration
REQ-027 Macro NEXT_PC_TRAP_EN: when defined, trap_req port exists; trap_req=1 with stall_req=0 gives pc_next=TRAP_ADDR, pc_en=1, flush=1; with stall_req=1 TRAP_ADDR is captured as pending (overriding a same-cycle branch; a later branch in HOLD SHALL NOT overwrite a pending trap).
REQ-028 When NEXT_PC_TRAP_EN is undefined, trap_req port is absent and behaviour equals trap_req=0 permanently.

Verification
REQ-029 pc_cur=0x0000_0010, all requests 0 -> pc_next=0x0000_0014, pc_en=1, flush=0.
REQ-030 pc_cur=0xFFFF_FFFC, no requests -> pc_next=0x0000_0000, pc_en=1.
REQ-031 br_taken=1, br_target=0x0000_0203, stall 0 -> pc_next=0x0000_0200, pc_en=1, flush=1 same cycle.
REQ-032 stall_req=1 3 cycles with br_taken=1, target 0x40 in cycle 1 and 0x80 in cycle 2 -> pc_en=0, redir_pend=1 from cycle 2; cycle 4 stall 0 -> pc_next=0x80, flush=1, redir_pend=0 in cycle 5.
REQ-033 STALL_MAX=4, stall_req=1 for 5 cycles then 0 -> stall_timeout=1 after 4th stall cycle and remains 1; rst_n pulse clears it.
REQ-034 NEXT_PC_TRAP_EN defined, trap_req=1 and br_taken=1 (target 0x40), stall 0 -> pc_next=0x0000_0100, flush=1; rst_n=0 during HOLD -> redir_pend=0 immediately.
